reaction_screen_ctrl: RTL and testbench



---
 rtl/reaction_screen_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_reaction_screen_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_screen_ctrl.sv
// ----------------------------------------------------------------------------
// reaction_screen_ctrl
//
// Sequences the reaction-time game across the full-screen OLED images
// (TITLE, WAIT, GO, RESULT, EARLY, SLOW). It produces the registered
// screen_sel code for the top-level pixel mux. It also generates the random
// pre-GO delay from a 16-bit LFSR, measures the reaction time in ms and
// times how long each end screen is held.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   tick_1ms     in   one-cycle pulse every 1 ms (synchronous to clk)
//   btn_pulse    in   one-cycle debounced press (synchronous to clk)
//   screen_sel   out  [2:0]  0 TITLE, 1 WAIT, 2 GO, 3 RESULT, 4 EARLY, 5 SLOW
//   reaction_ms  out  [13:0] last measured reaction time, saturates at 9999
//   result_valid out  one-cycle pulse when reaction_ms is updated
//   busy         out  high in every state except TITLE
//
// Optional feature, macro REACTION_BEST_EN:
//   best_ms      out  [13:0] best reaction time so far (reset 9999)
//   new_best     out  one-cycle pulse with result_valid when best_ms improves
//
// DELAY_MIN_MS + DELAY_MASK must stay below 65536 so that the 16-bit target
// sum cannot wrap.
// ----------------------------------------------------------------------------
module reaction_screen_ctrl #(
    parameter int          DELAY_MIN_MS = 1000,
    parameter logic [15:0] DELAY_MASK   = 16'h07FF,
    parameter int          TIMEOUT_MS   = 2000,
    parameter int          HOLD_MS      = 3000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_1ms,
    input  logic        btn_pulse,
    output logic [2:0]  screen_sel,
    output logic [13:0] reaction_ms,
    output logic        result_valid,
`ifdef REACTION_BEST_EN
    output logic [13:0] best_ms,
    output logic        new_best,
`endif
    output logic        busy
);

    typedef enum logic [2:0] {
        S_TITLE  = 3'd0,
        S_WAIT   = 3'd1,
        S_GO     = 3'd2,
        S_RESULT = 3'd3,
        S_EARLY  = 3'd4,
        S_SLOW   = 3'd5
    } state_t;

    // A zero seed would lock the LFSR at zero, so fall back to the default.
    localparam logic [15:0] LFSR_INIT  = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [15:0] DELAY_MIN  = 16'(DELAY_MIN_MS);
    localparam logic [16:0] TIMEOUT_C  = 17'(TIMEOUT_MS);
    localparam logic [16:0] HOLD_C     = 17'(HOLD_MS);
    localparam logic [15:0] SAT_MS     = 16'd9999;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_lfsr;
    logic [15:0] r_cnt;
    logic [15:0] r_target;
    logic [2:0]  r_screen_sel;
    logic [13:0] r_reaction_ms;
    logic        r_result_valid;
    logic        r_busy;

    logic [16:0] w_cnt_inc;
    logic        w_tgt_hit;
    logic        w_timeout_hit;
    logic        w_hold_hit;
    logic        w_load_target;
    logic        w_capture;
    logic [13:0] w_react_sat;

    // The counter value this tick would produce; a limit is "reached" on the
    // tick that would make the count equal to it. 17 bits so it cannot wrap.
    assign w_cnt_inc     = {1'b0, r_cnt} + 17'd1;
    assign w_tgt_hit     = tick_1ms && (w_cnt_inc >= {1'b0, r_target});
    assign w_timeout_hit = tick_1ms && (w_cnt_inc >= TIMEOUT_C);
    assign w_hold_hit    = tick_1ms && (w_cnt_inc >= HOLD_C);
    // The capture uses the pre-tick count: a tick coincident with the press is not counted.
    assign w_react_sat   = (r_cnt > SAT_MS) ? SAT_MS[13:0] : r_cnt[13:0];

    // Next-state decode and per-transition strobes.
    always_comb begin
        w_state_nxt   = r_state;
        w_load_target = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            S_TITLE: begin
                if (btn_pulse) begin
                    w_state_nxt   = S_WAIT;
                    w_load_target = 1'b1;
                end else begin
                    w_state_nxt = S_TITLE;
                end
            end
            S_WAIT: begin
                // A press beats a simultaneous expiry tick.
                if (btn_pulse) begin
                    w_state_nxt = S_EARLY;
                end else if (w_tgt_hit) begin
                    w_state_nxt = S_GO;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_GO: begin
                if (btn_pulse) begin
                    w_state_nxt = S_RESULT;
                    w_capture   = 1'b1;
                end else if (w_timeout_hit) begin
                    w_state_nxt = S_SLOW;
                end else begin
                    w_state_nxt = S_GO;
                end
            end
            S_RESULT, S_EARLY, S_SLOW: begin
                // Presses are ignored while an end screen is held.
                if (w_hold_hit) begin
                    w_state_nxt = S_TITLE;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = S_TITLE;
            end
        endcase
    end

    // State register plus registered screen_sel and busy, all updated on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_TITLE;
            r_screen_sel <= 3'd0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_screen_sel <= w_state_nxt;
            r_busy       <= (w_state_nxt != S_TITLE);
        end
    end

    // Free-running Fibonacci LFSR (taps 16,14,13,11) for the random delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_INIT;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    // Single ms counter: cleared on every state entry, counts ticks otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 16'd0;
        end else if (w_state_nxt != r_state) begin
            r_cnt <= 16'd0;
        end else if (tick_1ms) begin
            r_cnt <= w_cnt_inc[15:0];
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // WAIT target, sampled from the LFSR value held before the TITLE press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= 16'd0;
        end else if (w_load_target) begin
            r_target <= DELAY_MIN + (r_lfsr & DELAY_MASK);
        end else begin
            r_target <= r_target;
        end
    end

    // Reaction result register and its one-cycle valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reaction_ms  <= 14'd0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= w_capture;
            if (w_capture) begin
                r_reaction_ms <= w_react_sat;
            end else begin
                r_reaction_ms <= r_reaction_ms;
            end
        end
    end

`ifdef REACTION_BEST_EN
    logic [13:0] r_best_ms;
    logic        r_new_best;

    // Best-time tracker, updated on the same edge as reaction_ms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_ms  <= SAT_MS[13:0];
            r_new_best <= 1'b0;
        end else if (w_capture && (w_react_sat < r_best_ms)) begin
            r_best_ms  <= w_react_sat;
            r_new_best <= 1'b1;
        end else begin
            r_best_ms  <= r_best_ms;
            r_new_best <= 1'b0;
        end
    end

    assign best_ms  = r_best_ms;
    assign new_best = r_new_best;
`endif

    assign screen_sel   = r_screen_sel;
    assign reaction_ms  = r_reaction_ms;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_reaction_screen_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for reaction_screen_ctrl. Two instances share clock and reset:
// u0 has a long timeout (12000 ms) and u1 a short one (10 ms); both use
// DELAY_MIN_MS=4, DELAY_MASK=3 and HOLD_MS=5. A reference model tracks
// screen, elapsed ms, target and results for each instance and is compared
// every cycle, alongside a vector table and directed corner sequences.
// ----------------------------------------------------------------------------
module tb_reaction_screen_ctrl;

    localparam int DMIN = 4;
    localparam int MASK = 3;
    localparam int HOLD = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        btn0, tick0, btn1, tick1;
    logic [2:0]  sel0, sel1;
    logic [13:0] rms0, rms1;
    logic        rv0, rv1, busy0, busy1;
`ifdef REACTION_BEST_EN
    logic [13:0] best0, best1;
    logic        nb0, nb1;
`endif

    reaction_screen_ctrl #(.DELAY_MIN_MS(4), .DELAY_MASK(16'h0003), .TIMEOUT_MS(12000),
                           .HOLD_MS(5), .LFSR_SEED(16'hACE1)) u0 (
        .clk(clk), .rst_n(rst_n), .tick_1ms(tick0), .btn_pulse(btn0),
        .screen_sel(sel0), .reaction_ms(rms0), .result_valid(rv0),
`ifdef REACTION_BEST_EN
        .best_ms(best0), .new_best(nb0),
`endif
        .busy(busy0));

    reaction_screen_ctrl #(.DELAY_MIN_MS(4), .DELAY_MASK(16'h0003), .TIMEOUT_MS(10),
                           .HOLD_MS(5), .LFSR_SEED(16'hACE1)) u1 (
        .clk(clk), .rst_n(rst_n), .tick_1ms(tick1), .btn_pulse(btn1),
        .screen_sel(sel1), .reaction_ms(rms1), .result_valid(rv1),
`ifdef REACTION_BEST_EN
        .best_ms(best1), .new_best(nb1),
`endif
        .busy(busy1));

    int errors = 0;
    int checks = 0;

    // Reference model state per instance
    int          m_sel[2];
    int          m_cnt[2];
    int          m_tgt[2];
    int          m_react[2];
    int          m_rv[2];
    int          m_best[2];
    int          m_nb[2];
    logic [15:0] m_lfsr[2];
    int          m_to[2] = '{12000, 10};

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sel[k] = 0; m_cnt[k] = 0; m_tgt[k] = 0; m_react[k] = 0;
            m_rv[k] = 0; m_best[k] = 9999; m_nb[k] = 0; m_lfsr[k] = 16'hACE1;
        end
    endtask

    // Elapsed-ms game model: a limit is met on the tick that makes elapsed == limit.
    task automatic model_step(input int k, input bit b, input bit t);
        int          elapsed;
        logic [15:0] lf;
        elapsed   = m_cnt[k] + (t ? 1 : 0);
        lf        = m_lfsr[k];
        m_lfsr[k] = lfsr_next(lf);
        m_rv[k]   = 0;
        m_nb[k]   = 0;
        case (m_sel[k])
            0: if (b) begin
                   m_sel[k] = 1; m_cnt[k] = 0;
                   m_tgt[k] = DMIN + int'(lf & 16'(MASK));
               end
            1: if (b) begin m_sel[k] = 4; m_cnt[k] = 0; end
               else if (t && elapsed == m_tgt[k]) begin m_sel[k] = 2; m_cnt[k] = 0; end
               else m_cnt[k] = elapsed;
            2: if (b) begin
                   m_react[k] = (m_cnt[k] > 9999) ? 9999 : m_cnt[k];
                   m_rv[k] = 1;
                   if (m_react[k] < m_best[k]) begin m_best[k] = m_react[k]; m_nb[k] = 1; end
                   m_sel[k] = 3; m_cnt[k] = 0;
               end else if (t && elapsed == m_to[k]) begin m_sel[k] = 5; m_cnt[k] = 0; end
               else m_cnt[k] = elapsed;
            default: if (t && elapsed == HOLD) begin m_sel[k] = 0; m_cnt[k] = 0; end
                     else m_cnt[k] = elapsed;
        endcase
    endtask

    // One clock: drive, step the model at the edge, compare on the falling edge.
    task automatic cyc(input bit b0, input bit t0, input bit b1, input bit t1);
        btn0 = b0; tick0 = t0; btn1 = b1; tick1 = t1;
        @(posedge clk);
        model_step(0, b0, t0);
        model_step(1, b1, t1);
        @(negedge clk);
        chk("u0 screen_sel", sel0, m_sel[0]);
        chk("u0 result_valid", rv0, m_rv[0]);
        chk("u0 reaction_ms", rms0, m_react[0]);
        chk("u0 busy", busy0, (m_sel[0] != 0) ? 1 : 0);
        chk("u1 screen_sel", sel1, m_sel[1]);
        chk("u1 result_valid", rv1, m_rv[1]);
        chk("u1 reaction_ms", rms1, m_react[1]);
        chk("u1 busy", busy1, (m_sel[1] != 0) ? 1 : 0);
`ifdef REACTION_BEST_EN
        chk("u0 best_ms", best0, m_best[0]);
        chk("u0 new_best", nb0, m_nb[0]);
        chk("u1 best_ms", best1, m_best[1]);
        chk("u1 new_best", nb1, m_nb[1]);
`endif
    endtask

    task automatic act(input int k, input bit b, input bit t);
        if (k == 0) cyc(b, t, 1'b0, 1'b0);
        else        cyc(1'b0, 1'b0, b, t);
    endtask

    function automatic int sel_of(input int k);
        return (k == 0) ? int'(sel0) : int'(sel1);
    endfunction

    // Press in TITLE, then tick until GO (bounded).
    task automatic to_go(input int k);
        int n;
        n = 0;
        act(k, 1'b1, 1'b0);
        while (m_sel[k] != 2 && n < 20) begin
            act(k, 1'b0, 1'b1);
            n++;
        end
        chk("reach GO within bound", (n < 20) ? 1 : 0, 1);
        chk("in GO", sel_of(k), 2);
    endtask

    task automatic hold_out(input int k);
        repeat (HOLD) act(k, 1'b0, 1'b1);
        chk("back to TITLE", sel_of(k), 0);
    endtask

    task automatic do_reset();
        btn0 = 1'b0; tick0 = 1'b0; btn1 = 1'b0; tick1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit btn;
        bit tick;
        int reps;
        int sel;
        int rv;
        int react;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int n;
        // Normal round (target 6) then an early press, all on u0.
        tbl[0]  = '{1'b1, 1'b0, 1,  1, 0, 0};   // press in TITLE -> WAIT
        tbl[1]  = '{1'b0, 1'b1, 5,  1, 0, 0};   // 5 ticks: still WAIT
        tbl[2]  = '{1'b0, 1'b1, 1,  2, 0, 0};   // 6th tick -> GO
        tbl[3]  = '{1'b0, 1'b1, 37, 2, 0, 0};   // 37 ms in GO
        tbl[4]  = '{1'b1, 1'b0, 1,  3, 1, 37};  // press -> RESULT 37
        tbl[5]  = '{1'b0, 1'b0, 1,  3, 0, 37};  // valid was a single cycle
        tbl[6]  = '{1'b1, 1'b1, 4,  3, 0, 37};  // presses ignored in hold
        tbl[7]  = '{1'b0, 1'b1, 1,  0, 0, 37};  // 5th hold tick -> TITLE
        tbl[8]  = '{1'b1, 1'b0, 1,  1, 0, 37};  // new round
        tbl[9]  = '{1'b0, 1'b1, 2,  1, 0, 37};  // 2 ticks into WAIT
        tbl[10] = '{1'b1, 1'b0, 1,  4, 0, 37};  // early press -> EARLY
        tbl[11] = '{1'b0, 1'b1, 5,  0, 0, 37};  // hold -> TITLE, result kept

        btn0 = 1'b0; tick0 = 1'b0; btn1 = 1'b0; tick1 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset screen_sel", sel0, 0);
        chk("reset busy", busy0, 0);
        chk("reset reaction_ms", rms0, 0);
        chk("reset result_valid", rv0, 0);
        rst_n = 1'b1;
        model_reset();

        // Wait until the LFSR low bits give an extra delay of 2 ms.
        n = 0;
        while ((m_lfsr[0] & 16'h0003) != 16'h0002 && n < 64) begin
            act(0, 1'b0, 1'b0);
            n++;
        end
        chk("lfsr align bound", (n < 64) ? 1 : 0, 1);

        for (int i = 0; i < 12; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) act(0, tbl[i].btn, tbl[i].tick);
            chk($sformatf("vec%0d screen_sel", i), sel0, tbl[i].sel);
            chk($sformatf("vec%0d result_valid", i), rv0, tbl[i].rv);
            chk($sformatf("vec%0d reaction_ms", i), rms0, tbl[i].react);
            chk($sformatf("vec%0d busy", i), busy0, (tbl[i].sel != 0) ? 1 : 0);
        end

        // Press on the expiring WAIT tick -> EARLY.
        act(0, 1'b1, 1'b0);
        n = 0;
        while (m_cnt[0] != m_tgt[0] - 1 && n < 20) begin
            act(0, 1'b0, 1'b1);
            n++;
        end
        chk("wait expiry bound", (n < 20) ? 1 : 0, 1);
        act(0, 1'b1, 1'b1);
        chk("press on expiry -> EARLY", sel0, 4);
        hold_out(0);

        // Press with a tick in GO at count 20 -> 20.
        to_go(0);
        repeat (20) act(0, 1'b0, 1'b1);
        act(0, 1'b1, 1'b1);
        chk("press+tick screen_sel", sel0, 3);
        chk("press+tick reaction_ms", rms0, 20);
        chk("press+tick result_valid", rv0, 1);
        hold_out(0);

        // Timeout on u1 at tick 10, no result.
        to_go(1);
        repeat (9) act(1, 1'b0, 1'b1);
        chk("before timeout", sel1, 2);
        act(1, 1'b0, 1'b1);
        chk("timeout -> SLOW", sel1, 5);
        chk("timeout result_valid", rv1, 0);
        chk("timeout reaction_ms", rms1, 0);
        hold_out(1);

        // Saturation: press at count 10500.
        to_go(0);
        repeat (10500) act(0, 1'b0, 1'b1);
        act(0, 1'b1, 1'b0);
        chk("saturated reaction_ms", rms0, 9999);
        chk("saturated result_valid", rv0, 1);
        hold_out(0);

        // Asynchronous reset mid-GO, checked before any clock edge.
        to_go(0);
        repeat (3) act(0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midGO reset screen_sel", sel0, 0);
        chk("midGO reset busy", busy0, 0);
        chk("midGO reset reaction_ms", rms0, 0);
        chk("midGO reset result_valid", rv0, 0);
        chk("midGO reset lfsr", u0.r_lfsr, 32'hACE1);
`ifdef REACTION_BEST_EN
        chk("midGO reset best_ms", best0, 9999);
`endif
        @(negedge clk);
        do_reset();

`ifdef REACTION_BEST_EN
        begin
            int res[3]  = '{300, 250, 400};
            int bst[3]  = '{300, 250, 250};
            int nbe[3]  = '{1, 1, 0};
            for (int i = 0; i < 3; i++) begin
                to_go(0);
                repeat (res[i]) act(0, 1'b0, 1'b1);
                act(0, 1'b1, 1'b0);
                chk($sformatf("best round%0d reaction_ms", i), rms0, res[i]);
                chk($sformatf("best round%0d best_ms", i), best0, bst[i]);
                chk($sformatf("best round%0d new_best", i), nb0, nbe[i]);
                hold_out(0);
            end
        end
`endif

        // Randomised traffic on both instances against the model.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
